// File: rtl/ula_pkg.sv
// Shared constants and helpers for the ULA audio path: default sample geometry,
// accumulator sizing and PCM saturation.
package ula_pkg;

  localparam int DEF_PCM_W = 16;
  localparam int DEF_OSR_W = 6;

  // Largest per-cycle term is 15 per channel, plus 15 headroom for the tape source.
  function automatic int acc_width(input int nch, input int osr_w, input bit tape);
    return $clog2((nch * 15 + (tape ? 15 : 0)) * (1 << osr_w) + 1);
  endfunction

  function automatic logic [63:0] sat_pcm(input logic [63:0] value, input int width);
    logic [63:0] max_pos;
    max_pos = (64'd1 << (width - 1)) - 64'd1;
    return (value > max_pos) ? max_pos : value;
  endfunction

endpackage

// File: rtl/ula_edge_divider.sv
// Counts rising edges of a level and toggles its output every DIV edges.
// Latency: toggle updates 2 clocks after the level rises; no backpressure.
module ula_edge_divider #(
  parameter int DIV = 128
) (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic toggle
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

  logic          lvl_q;
  logic          lvl_q2;
  logic [CW-1:0] cnt;
  logic          rise;

  assign rise = lvl_q & ~lvl_q2;

  always_ff @(posedge clk) begin
    if (reset) begin
      lvl_q  <= 1'b0;
      lvl_q2 <= 1'b0;
      cnt    <= RELOAD;
      toggle <= 1'b0;
    end else begin
      lvl_q  <= level;
      lvl_q2 <= lvl_q;
      if (rise) begin
        if (cnt == '0) begin
          toggle <= ~toggle;
          cnt    <= RELOAD;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ula_beeper_mixer.sv
// Weighted 1-bit source mixer averaged over 2^OSR_W clocks into a saturated PCM sample;
// one-entry valid/ready output buffer drops new samples (sticky overrun) when full. Option: ULA_TAPE_MONITOR_EN.
module ula_beeper_mixer
  import ula_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int PCM_W     = DEF_PCM_W,
  parameter int OSR_W     = DEF_OSR_W,
  parameter int SHIFT     = 8,
  parameter int BLINK_DIV = 128,
  parameter int TAPE_WT   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   src,
  input  logic [NCH-1:0]   ch_en,
  input  logic [4*NCH-1:0] ch_wt,
  input  logic             tape_in,
  output logic [PCM_W-1:0] pcm_out,
  output logic             pcm_valid,
  input  logic             pcm_ready,
  output logic             overrun,
  output logic             blink
);

`ifdef ULA_TAPE_MONITOR_EN
  localparam bit TAPE_ON = 1'b1;
`else
  localparam bit TAPE_ON = 1'b0;
`endif
  localparam int ACC_W = acc_width(NCH, OSR_W, TAPE_ON);

  logic [OSR_W-1:0] wc;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] term;
  logic [ACC_W-1:0] sum;
  logic [63:0]      scaled;
  logic [PCM_W-1:0] sample;
  logic             win_end;
  logic             blink_level;

  always_comb begin
    term = '0;
    for (int i = 0; i < NCH; i++) begin
      if (src[i] && ch_en[i]) term = term + ACC_W'(ch_wt[4*i +: 4]);
    end
`ifdef ULA_TAPE_MONITOR_EN
    if (tape_in) term = term + ACC_W'(TAPE_WT);
`endif
  end

`ifdef ULA_TAPE_MONITOR_EN
  assign blink_level = src[0] ^ tape_in;
`else
  logic unused_tape;
  assign unused_tape = tape_in;
  assign blink_level = src[0];
`endif

  assign win_end = &wc;
  assign sum     = acc + term;
  assign scaled  = 64'(sum >> OSR_W) << SHIFT;
  assign sample  = PCM_W'(sat_pcm(scaled, PCM_W));

  always_ff @(posedge clk) begin
    if (reset) begin
      wc        <= '0;
      acc       <= '0;
      pcm_out   <= '0;
      pcm_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      wc <= wc + 1'b1;
      if (win_end) begin
        acc <= '0;
        // A consumer taking the held sample this cycle frees the slot for the new one.
        if (!pcm_valid || pcm_ready) begin
          pcm_out   <= sample;
          pcm_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else begin
        acc <= sum;
        if (pcm_valid && pcm_ready) pcm_valid <= 1'b0;
      end
    end
  end

  ula_edge_divider #(
    .DIV(BLINK_DIV)
  ) u_blink (
    .clk   (clk),
    .reset (reset),
    .level (blink_level),
    .toggle(blink)
  );

endmodule
